reg_bus_csr_responder: RTL

// - Component-side end of the host register bus: decodes reg_bus_wvalid/waddr/wdata writes and
//   reg_bus_arvalid/araddr reads, and returns reg_bus_rvalid/rdata for one component slot.
// - Holds the component's writable config registers and 64-bit event counters, with atomic
//   LSB/MSB counter reads. One instance sits in each tile unit behind the reg bus fan-out.

---
 rtl/reg_bus_csr_responder_pkg.sv | 47 ++++
 rtl/reg_bus_csr_responder_counter.sv | 25 ++
 rtl/reg_bus_csr_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/reg_bus_csr_responder_pkg.sv
// Shared register-bus types, CSR offsets and the offset decoder for component CSR blocks.
package reg_bus_csr_responder_pkg;

  typedef logic [31:0] reg_data_t;

  localparam logic [7:0] CSR_CFG_BASE  = 8'h00;
  localparam logic [7:0] CSR_CTR_BASE  = 8'h40;
  localparam logic [7:0] CSR_CTR_CLEAR = 8'h80;
  localparam logic [7:0] CSR_CTR_EN    = 8'h84;
  localparam logic [7:0] CSR_COMP_ID   = 8'h88;

  typedef enum logic [2:0] {
    CSR_NONE,
    CSR_CFG,
    CSR_CTR_LSB,
    CSR_CTR_MSB,
    CSR_CLEAR,
    CSR_EN,
    CSR_ID
  } csr_kind_e;

  typedef struct packed {
    csr_kind_e  kind;
    logic [3:0] idx;
  } csr_dec_t;

  // Index range checks are left to the caller since they depend on its parameters.
  function automatic csr_dec_t csr_decode(input logic [7:0] addr);
    csr_dec_t d;
    d.kind = CSR_NONE;
    d.idx  = addr[5:2];
    if (addr[7:6] == CSR_CFG_BASE[7:6]) begin
      d.kind = CSR_CFG;
    end else if (addr[7:6] == CSR_CTR_BASE[7:6]) begin
      d.kind = addr[2] ? CSR_CTR_MSB : CSR_CTR_LSB;
      d.idx  = {1'b0, addr[5:3]};
    end else if (addr[7:2] == CSR_CTR_CLEAR[7:2]) begin
      d.kind = CSR_CLEAR;
    end else if (addr[7:2] == CSR_CTR_EN[7:2]) begin
      d.kind = CSR_EN;
    end else if (addr[7:2] == CSR_COMP_ID[7:2]) begin
      d.kind = CSR_ID;
    end
    return d;
  endfunction

endpackage

// File: rtl/reg_bus_csr_responder_counter.sv
// 64-bit wrapping event counter; clear has priority over a same-cycle increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        inc,
  output logic [63:0] value
);

  logic [63:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && inc) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/reg_bus_csr_responder.sv
// Component-side CSR responder: config registers, event counters with atomic LSB/MSB reads,
// and a fixed two-cycle read pipeline.
module reg_bus_csr_responder
  import reg_bus_csr_responder_pkg::*;
#(
  parameter int COMP_ID = 1,
  parameter int N_CFG   = 8,
  parameter int N_CTR   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_bus_wvalid,
  input  logic [15:0]        reg_bus_waddr,
  input  logic [31:0]        reg_bus_wdata,
  input  logic               reg_bus_arvalid,
  input  logic [15:0]        reg_bus_araddr,
  output logic               reg_bus_rvalid,
  output reg_data_t          reg_bus_rdata,
  output logic [N_CFG*32-1:0] cfg_out,
  input  logic [N_CTR-1:0]   evt_inc
);

  csr_dec_t         wdec;
  csr_dec_t         rdec;
  logic [31:0]      cfg_q [N_CFG];
  logic [63:0]      ctr_val [N_CTR];
  logic [N_CTR-1:0] en_q;
  logic [N_CTR-1:0] clr_mask;
  logic [31:0]      shadow_q;
  logic [31:0]      shadow_nxt;
  reg_data_t        rd_val;
  logic             s1_vld;
  reg_data_t        s1_dat;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^{reg_bus_waddr[15:8], reg_bus_araddr[15:8]};

  assign wdec     = csr_decode(reg_bus_waddr[7:0]);
  assign rdec     = csr_decode(reg_bus_araddr[7:0]);
  assign clr_mask = (reg_bus_wvalid && wdec.kind == CSR_CLEAR) ? reg_bus_wdata[N_CTR-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CFG; i++) cfg_q[i] <= '0;
      en_q <= '1;
    end else if (reg_bus_wvalid) begin
      for (int i = 0; i < N_CFG; i++) begin
        if (wdec.kind == CSR_CFG && wdec.idx == 4'(i)) cfg_q[i] <= reg_bus_wdata;
      end
      if (wdec.kind == CSR_EN) en_q <= reg_bus_wdata[N_CTR-1:0];
    end
  end

  always_comb begin
    cfg_out = '0;
    for (int i = 0; i < N_CFG; i++) cfg_out[i*32 +: 32] = cfg_q[i];
  end

  for (genvar k = 0; k < N_CTR; k++) begin : g_ctr
    csr_counter64 u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (en_q[k]),
      .clr   (clr_mask[k]),
      .inc   (evt_inc[k]),
      .value (ctr_val[k])
    );
  end

  // An LSB read latches the matching upper half so the following MSB read is coherent.
  always_comb begin
    rd_val     = '0;
    shadow_nxt = shadow_q;
    case (rdec.kind)
      CSR_CFG: begin
        for (int i = 0; i < N_CFG; i++) begin
          if (rdec.idx == 4'(i)) rd_val = cfg_q[i];
        end
      end
      CSR_CTR_LSB: begin
        for (int k = 0; k < N_CTR; k++) begin
          if (rdec.idx == 4'(k)) begin
            rd_val = ctr_val[k][31:0];
            if (reg_bus_arvalid) shadow_nxt = ctr_val[k][63:32];
          end
        end
      end
      CSR_CTR_MSB: begin
        for (int k = 0; k < N_CTR; k++) begin
          if (rdec.idx == 4'(k)) rd_val = shadow_q;
        end
      end
      CSR_EN:  rd_val = 32'(en_q);
      CSR_ID:  rd_val = 32'(COMP_ID);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q       <= '0;
      s1_vld         <= 1'b0;
      s1_dat         <= '0;
      reg_bus_rvalid <= 1'b0;
      reg_bus_rdata  <= '0;
    end else begin
      shadow_q       <= shadow_nxt;
      s1_vld         <= reg_bus_arvalid;
      s1_dat         <= rd_val;
      reg_bus_rvalid <= s1_vld;
      if (s1_vld) reg_bus_rdata <= s1_dat;
    end
  end

endmodule
